uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the payload width per frame; legal values are 5 to 9.
REQ-002 Parameter PARITY_EN, default 1'b0, SHALL insert one parity bit after the data bits when 1.
REQ-003 Parameter PARITY_ODD, default 1'b0, SHALL select odd parity when 1 and even parity when 0; it is ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1, SHALL set the number of stop-bit periods; legal values are 1 and 2.
REQ-005 clkIn, input, 1: system clock; all state changes occur on its rising edge.
REQ-006 rstIn, input, 1: reset, asynchronous, active-high.
REQ-007 tickIn, input, 1: baud tick, one clkIn cycle wide, driven by the upstream counter done pulse; one bit period equals the interval between consecutive ticks.
REQ-008 dataIn, input, DATA_BITS: payload to transmit, sampled on acceptance.
REQ-009 validIn, input, 1: payload-offered strobe from the producer.
REQ-010 readyOut, output, 1: the block can accept a payload.
REQ-011 txOut, output, 1: serial line; idle level is 1.
REQ-012 busyOut, output, 1: a frame is pending or in progress.
REQ-013 doneOut, output, 1: one-cycle pulse marking frame completion.

Function
REQ-014 States SHALL be IDLE, ARMED, START, DATA, PARITY, STOP; all outputs are registered or decoded from registered state only.
REQ-015 readyOut SHALL equal 1 only in IDLE; busyOut SHALL equal NOT readyOut.
REQ-016 Acceptance SHALL occur on a clkIn edge with validIn=1 and readyOut=1; dataIn is latched into a shift register at that edge and the state becomes ARMED.
REQ-017 validIn SHALL be ignored when readyOut=0, and changes to dataIn after acceptance SHALL NOT affect the frame in flight.
REQ-018 tickIn SHALL be ignored in IDLE, including a tick coincident with acceptance.
REQ-019 ARMED holds txOut=1; the first tickIn SHALL move the state to START with txOut=0.
REQ-020 In START, the next tickIn SHALL move the state to DATA and drive data bit 0; transmission is LSB-first.
REQ-021 In DATA, each tickIn SHALL drive the next bit; after bit DATA_BITS-1 has occupied one tick period, the next tickIn goes to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-022 The parity bit SHALL equal the XOR of the latched data bits, inverted when PARITY_ODD=1; the next tickIn goes to STOP.
REQ-023 STOP SHALL drive txOut=1 for STOP_BITS tick periods; the tickIn ending the last period SHALL return the state to IDLE and pulse doneOut=1 for exactly that one cycle.
REQ-024 Frame length from the START entry tick to the doneOut tick SHALL be 1+DATA_BITS+PARITY_EN+STOP_BITS ticks.
REQ-025 A payload offered with validIn=1 in the cycle the state returns to IDLE SHALL be accepted on the following edge, when readyOut=1; there is no other back-to-back bypass.
REQ-026 The bit index counter SHALL be sized to hold DATA_BITS-1 and SHALL reset to 0 on every entry to DATA.
REQ-027 Between ticks, txOut SHALL hold its value; txOut SHALL never glitch within a bit period.

Reset
REQ-028 On rstIn=1, the block SHALL immediately and asynchronously set state=IDLE, txOut=1, doneOut=0, the shift register to 0, and the bit counter to 0, which gives readyOut=1 and busyOut=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no doneOut pulse; the first acceptance after release starts a fresh frame.

Verification
REQ-030 Config 8N1, dataIn=0xA5, validIn for 1 cycle, tick every 16 clocks -> txOut per tick: 0,1,0,1,0,0,1,0,1,1; doneOut on the 11th tick after acceptance; readyOut=0 throughout the frame.
REQ-031 Config PARITY_EN=1: with PARITY_ODD=0 and dataIn=0xA5 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; with PARITY_ODD=0 and dataIn=0x01 -> parity bit 1.
REQ-032 Config STOP_BITS=2: stop level 1 for 2 tick periods, and doneOut on the 12th tick for 8N2.
REQ-033 Acceptance coincident with tickIn, then validIn held high with dataIn changed to 0x3C -> the first frame carries the original byte, start begins at the next tick, and 0x3C is accepted the cycle after doneOut.
REQ-034 rstIn pulsed during DATA bit 4 -> txOut=1 within the same cycle, no doneOut pulse, readyOut=1 after release; a new 0x5A frame transmits correctly.
REQ-035 Ticks applied in IDLE with validIn=0 for 100 cycles -> txOut stays 1, busyOut=0, doneOut=0.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- frame serialiser for an asynchronous serial line.
//
// Accepts one payload through a valid/ready handshake and shifts it out LSB
// first, framed by a start bit, an optional parity bit and one or two stop
// bits. Bit timing comes entirely from an external baud tick: every tick ends
// the current bit period and starts the next one. An accepted payload waits
// in ARMED until the first tick, so the start bit always lasts a full period.
//
// Parameters
//   DATA_BITS  payload width per frame (5..9)
//   PARITY_EN  1 inserts a parity bit after the data bits
//   PARITY_ODD 1 selects odd parity, 0 even (ignored when PARITY_EN=0)
//   STOP_BITS  number of stop-bit periods (1 or 2)
//
// Ports
//   clkIn     system clock, rising edge
//   rstIn     asynchronous, active-high reset
//   tickIn    one-cycle baud tick; interval between ticks is one bit period
//   dataIn    payload, sampled on acceptance
//   validIn   producer offers dataIn
//   readyOut  1 only while IDLE; a payload is accepted when valid & ready
//   txOut     registered serial line, idles at 1
//   busyOut   inverse of readyOut: a frame is pending or in progress
//   doneOut   one-cycle pulse on the tick that completes the final stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clkIn,
   input  logic                 rstIn,
   input  logic                 tickIn,
   input  logic [DATA_BITS-1:0] dataIn,
   input  logic                 validIn,
   output logic                 readyOut,
   output logic                 txOut,
   output logic                 busyOut,
   output logic                 doneOut
);

   // The bit index only has to reach DATA_BITS-1.
   localparam int                CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
   localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               stateQ,   stateD;
   logic [DATA_BITS-1:0] shiftQ,   shiftD;
   logic [CNT_W-1:0]     bitCntQ,  bitCntD;
   logic                 stopCntQ, stopCntD;
   logic                 parityQ,  parityD;
   logic                 txD;
   logic                 doneD;

   // --------------------------------------------------------------------------
   // State register: FSM state plus every datapath and output register.
   // --------------------------------------------------------------------------
   // NOTE: the async reset clears the shift register and counters along with
   // the state so an aborted frame leaves nothing behind for the next one.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         stateQ   <= IDLE;
         shiftQ   <= '0;
         bitCntQ  <= '0;
         stopCntQ <= 1'b0;
         parityQ  <= 1'b0;
         txOut    <= 1'b1;
         doneOut  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values present before the edge, independent of statement order.
         stateQ   <= stateD;
         shiftQ   <= shiftD;
         bitCntQ  <= bitCntD;
         stopCntQ <= stopCntD;
         parityQ  <= parityD;
         txOut    <= txD;
         doneOut  <= doneD;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic. Ticks are only looked at outside IDLE, so a tick that
   // coincides with acceptance does not shorten the start bit.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: default first so every path assigns stateD and no latch forms.
      stateD = stateQ;
      unique case (stateQ)
         IDLE:    if (validIn) stateD = ARMED;
         ARMED:   if (tickIn)  stateD = START;
         START:   if (tickIn)  stateD = DATA;
         DATA: begin
            if (tickIn && (bitCntQ == LAST_BIT))
               stateD = PARITY_EN ? PARITY : STOP;
         end
         PARITY:  if (tickIn)  stateD = STOP;
         STOP: begin
            if (tickIn && (stopCntQ == LAST_STOP))
               stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Output / datapath logic: next values for the line, the done pulse, the
   // shift register and the counters. txOut only changes on a tick, so the
   // line is stable for the whole bit period.
   // --------------------------------------------------------------------------
   always_comb begin
      txD      = txOut;
      doneD    = 1'b0;
      shiftD   = shiftQ;
      bitCntD  = bitCntQ;
      stopCntD = stopCntQ;
      parityD  = parityQ;
      unique case (stateQ)
         IDLE: begin
            if (validIn) begin
               shiftD  = dataIn;
               // Parity is taken from the latched payload, before any shifting.
               parityD = (^dataIn) ^ PARITY_ODD;
            end
         end
         ARMED: begin
            if (tickIn) txD = 1'b0;
         end
         START: begin
            if (tickIn) begin
               txD     = shiftQ[0];
               shiftD  = shiftQ >> 1;
               bitCntD = '0;
            end
         end
         DATA: begin
            if (tickIn) begin
               if (bitCntQ == LAST_BIT) begin
                  txD      = PARITY_EN ? parityQ : 1'b1;
                  stopCntD = 1'b0;
               end else begin
                  txD     = shiftQ[0];
                  shiftD  = shiftQ >> 1;
                  bitCntD = bitCntQ + 1'b1;
               end
            end
         end
         PARITY: begin
            if (tickIn) begin
               txD      = 1'b1;
               stopCntD = 1'b0;
            end
         end
         STOP: begin
            if (tickIn) begin
               if (stopCntQ == LAST_STOP) doneD = 1'b1;
               else                       stopCntD = stopCntQ + 1'b1;
            end
         end
         default: begin
            txD = 1'b1;
         end
      endcase
   end

   assign readyOut = (stateQ == IDLE);
   assign busyOut  = ~readyOut;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Four instances share one stimulus stream: 8N1, 8E1, 8O1 and 8N2. Expected
// line levels come from a frame model: after acceptance, the k-th tick opens
// line period k, whose level is start(0), data bit k-2, parity, or stop(1);
// busy holds while k <= frame length and done pulses on tick length+1.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   logic       clkIn = 1'b0;
   logic       rstIn;
   logic       tickIn;
   logic       validIn;
   logic [7:0] dataIn;

   logic [3:0] txV, busyV, readyV, doneV;

   int         checks   = 0;
   int         failures = 0;
   logic [9:0] cap0;

   typedef struct {
      logic [7:0] data;
      int         gap;
      logic       coinc;
      logic       parEven;
   } vec_t;

   vec_t vecs[6];

   initial forever #5 clkIn = ~clkIn;

   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u0 (
      .clkIn(clkIn), .rstIn(rstIn), .tickIn(tickIn), .dataIn(dataIn), .validIn(validIn),
      .readyOut(readyV[0]), .txOut(txV[0]), .busyOut(busyV[0]), .doneOut(doneV[0]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u1 (
      .clkIn(clkIn), .rstIn(rstIn), .tickIn(tickIn), .dataIn(dataIn), .validIn(validIn),
      .readyOut(readyV[1]), .txOut(txV[1]), .busyOut(busyV[1]), .doneOut(doneV[1]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u2 (
      .clkIn(clkIn), .rstIn(rstIn), .tickIn(tickIn), .dataIn(dataIn), .validIn(validIn),
      .readyOut(readyV[2]), .txOut(txV[2]), .busyOut(busyV[2]), .doneOut(doneV[2]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u3 (
      .clkIn(clkIn), .rstIn(rstIn), .tickIn(tickIn), .dataIn(dataIn), .validIn(validIn),
      .readyOut(readyV[3]), .txOut(txV[3]), .busyOut(busyV[3]), .doneOut(doneV[3]));

   // ---------------- reference model ----------------
   function automatic bit parEn(input int i);
      return (i == 1) || (i == 2);
   endfunction

   function automatic bit parOdd(input int i);
      return (i == 2);
   endfunction

   function automatic int frameLen(input int i);
      return 1 + 8 + (parEn(i) ? 1 : 0) + ((i == 3) ? 2 : 1);
   endfunction

   // Line level during period k after acceptance (k=0: waiting for first tick).
   function automatic logic expLevel(input int i, input logic [7:0] d,
                                     input logic pe, input int k);
      if (k == 0)                   return 1'b1;
      if (k == 1)                   return 1'b0;
      if (k <= 9)                   return d[3'(k - 2)];
      if (parEn(i) && (k == 10))    return pe ^ parOdd(i);
      return 1'b1;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic sample(input int k, input bit atTick, input logic [7:0] d,
                         input logic pe, input logic [3:0] mask);
      logic [3:0] eTx, eBusy, eDone;
      for (int i = 0; i < 4; i++) begin
         eTx[i]   = expLevel(i, d, pe, k);
         eBusy[i] = (k <= frameLen(i));
         eDone[i] = atTick && (k == frameLen(i) + 1);
      end
      if (atTick && k >= 1 && k <= 10) cap0[k-1] = txV[0];
      check($sformatf("tx k=%0d", k),    32'(txV & mask),    32'(eTx & mask));
      check($sformatf("busy k=%0d", k),  32'(busyV & mask),  32'(eBusy & mask));
      check($sformatf("ready k=%0d", k), 32'(readyV & mask), 32'(~eBusy & mask));
      check($sformatf("done k=%0d", k),  32'(doneV & mask),  32'(eDone & mask));
   endtask

   // Offer one payload; dataIn is changed right after acceptance.
   task automatic accept(input logic [7:0] d, input logic coinc, input logic keep,
                         input logic [7:0] dAfter, input logic pe, input logic [3:0] mask);
      @(negedge clkIn);
      check("ready before accept", 32'(readyV & mask), 32'(4'hF & mask));
      validIn = 1'b1;
      dataIn  = d;
      tickIn  = coinc;
      @(negedge clkIn);
      tickIn = 1'b0;
      if (!keep) validIn = 1'b0;
      dataIn = dAfter;
      sample(0, 1'b0, d, pe, mask);
   endtask

   // n ticks spaced gap cycles apart, every cycle sampled.
   task automatic frameTicks(input logic [7:0] d, input logic pe, input int gap,
                             input logic [3:0] mask, input int n);
      for (int k = 1; k <= n; k++) begin
         for (int g = 1; g < gap; g++) begin
            @(negedge clkIn);
            sample(k - 1, 1'b0, d, pe, mask);
         end
         tickIn = 1'b1;
         @(negedge clkIn);
         tickIn = 1'b0;
         sample(k, 1'b1, d, pe, mask);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clkIn);
         check("idle tx",    32'(txV),    32'(4'hF));
         check("idle busy",  32'(busyV),  32'(4'h0));
         check("idle ready", 32'(readyV), 32'(4'hF));
         check("idle done",  32'(doneV),  32'(4'h0));
         tickIn = 1'($urandom_range(0, 1));
      end
      @(negedge clkIn);
      tickIn = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      int         rg;
      logic       rc;

      vecs[0] = '{8'hA5, 16, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 16, 1'b0, 1'b1};
      vecs[2] = '{8'h00,  3, 1'b1, 1'b0};
      vecs[3] = '{8'hFF,  2, 1'b0, 1'b0};
      vecs[4] = '{8'h80,  5, 1'b1, 1'b1};
      vecs[5] = '{8'h7E,  4, 1'b0, 1'b0};

      rstIn   = 1'b1;
      tickIn  = 1'b0;
      validIn = 1'b0;
      dataIn  = 8'h00;

      // Reset state
      @(negedge clkIn);
      check("reset tx",    32'(txV),    32'(4'hF));
      check("reset ready", 32'(readyV), 32'(4'hF));
      check("reset busy",  32'(busyV),  32'(4'h0));
      check("reset done",  32'(doneV),  32'(4'h0));
      @(negedge clkIn);
      rstIn = 1'b0;

      // Ticks in IDLE with no payload
      idleCycles(100);

      // Directed vectors
      for (int v = 0; v < 6; v++) begin
         accept(vecs[v].data, vecs[v].coinc, 1'b0, ~vecs[v].data, vecs[v].parEven, 4'hF);
         frameTicks(vecs[v].data, vecs[v].parEven, vecs[v].gap, 4'hF, 13);
         if (v == 0) check("8N1 0xA5 line pattern", 32'(cap0), 32'(10'h34A));
      end

      // Acceptance on a tick, valid held with new data: back-to-back on 8N1
      accept(8'h96, 1'b1, 1'b1, 8'h3C, 1'b0, 4'h1);
      frameTicks(8'h96, 1'b0, 4, 4'h1, 11);
      @(negedge clkIn);
      check("b2b accepted after done", 32'(readyV[0]), 32'd0);
      validIn = 1'b0;
      sample(0, 1'b0, 8'h3C, 1'b0, 4'h1);
      frameTicks(8'h3C, 1'b0, 4, 4'h1, 11);
      idleCycles(30);

      // Reset during data bit 4 (0xEF has bit 4 low)
      accept(8'hEF, 1'b0, 1'b0, 8'h00, 1'b1, 4'hF);
      frameTicks(8'hEF, 1'b1, 3, 4'hF, 6);
      #2 rstIn = 1'b1;
      #1;
      check("abort tx",    32'(txV),    32'(4'hF));
      check("abort ready", 32'(readyV), 32'(4'hF));
      check("abort done",  32'(doneV),  32'(4'h0));
      @(negedge clkIn);
      rstIn = 1'b0;
      idleCycles(40);
      accept(8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 4'hF);
      frameTicks(8'h5A, 1'b0, 3, 4'hF, 13);

      // Randomized frames against the model
      for (int r = 0; r < 20; r++) begin
         rd = 8'($urandom);
         rg = $urandom_range(1, 6);
         rc = 1'($urandom_range(0, 1));
         accept(rd, rc, 1'b0, 8'($urandom), ^rd, 4'hF);
         frameTicks(rd, ^rd, rg, 4'hF, 13);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
